// File: rtl/ni_flit_tx_pkg.sv
// Shared widths, flit encodings and head-flit layout for the NI packetizer.
package ni_flit_tx_pkg;

  localparam int X_WIDTH         = 2;
  localparam int Y_WIDTH         = 2;
  localparam int PKT_WIDTH       = 8;
  localparam int FLIT_DATA_WIDTH = 32;
  localparam int FLIT_TYPE_WIDTH = 2;
  localparam int FLIT_WIDTH      = FLIT_TYPE_WIDTH + FLIT_DATA_WIDTH;
  localparam int HEAD_USED       = 2 * X_WIDTH + 2 * Y_WIDTH + PKT_WIDTH + 1;

  typedef enum logic [FLIT_TYPE_WIDTH-1:0] {
    HEAD_FLIT = 2'b00,
    BODY_FLIT = 2'b01,
    TAIL_FLIT = 2'b10
  } flit_type_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_DRAIN   = 2'd2
  } ni_state_t;

  typedef struct packed {
    logic                  fvalid;
    logic [FLIT_WIDTH-1:0] flit_data;
  } s_flit_req_t;

  typedef struct packed {
    logic ready;
  } s_flit_resp_t;

  typedef struct packed {
    flit_type_t                           flit_type;
    logic [X_WIDTH-1:0]                   x_dest;
    logic [Y_WIDTH-1:0]                   y_dest;
    logic [X_WIDTH-1:0]                   x_src;
    logic [Y_WIDTH-1:0]                   y_src;
    logic [PKT_WIDTH:0]                   pkt_len;
    logic [FLIT_DATA_WIDTH-HEAD_USED-1:0] rsvd;
  } s_flit_head_data_t;

  function automatic logic [FLIT_WIDTH-1:0] mk_flit(flit_type_t t,
                                                    logic [FLIT_DATA_WIDTH-1:0] d);
    return {t, d};
  endfunction

endpackage

// File: rtl/ni_flit_tx_if.sv
// Tile-side command/payload handshakes and router LOCAL-port flit link.
interface ni_flit_tx_if;
  import ni_flit_tx_pkg::*;

  logic                       cmd_valid_i;
  logic                       cmd_ready_o;
  logic [X_WIDTH-1:0]         cmd_x_dest_i;
  logic [Y_WIDTH-1:0]         cmd_y_dest_i;
  logic [PKT_WIDTH-1:0]       cmd_len_i;
  logic                       data_valid_i;
  logic                       data_ready_o;
  logic [FLIT_DATA_WIDTH-1:0] data_i;
  s_flit_req_t                fout_req_o;
  s_flit_resp_t               fout_resp_i;

  modport master (
    output cmd_valid_i, cmd_x_dest_i, cmd_y_dest_i, cmd_len_i,
    output data_valid_i, data_i, fout_resp_i,
    input  cmd_ready_o, data_ready_o, fout_req_o
  );

  modport slave (
    input  cmd_valid_i, cmd_x_dest_i, cmd_y_dest_i, cmd_len_i,
    input  data_valid_i, data_i, fout_resp_i,
    output cmd_ready_o, data_ready_o, fout_req_o
  );

endinterface

// File: rtl/ni_flit_tx_slot.sv
// Single-entry flit output register: a load shows up one cycle later, and the
// flit is held stable while the router withholds ready.
module flit_out_slot
  import ni_flit_tx_pkg::*;
(
  input  logic                  clk,
  input  logic                  arst,
  input  logic                  load,
  input  logic [FLIT_WIDTH-1:0] load_dat,
  output s_flit_req_t           fout_req,
  input  s_flit_resp_t          fout_resp,
  output logic                  slot_free
);

  assign slot_free = !fout_req.fvalid || fout_resp.ready;

  always_ff @(posedge clk) begin
    if (arst) begin
      fout_req <= '0;
    end else if (load) begin
      fout_req.fvalid    <= 1'b1;
      fout_req.flit_data <= load_dat;
    end else if (slot_free) begin
      fout_req.fvalid <= 1'b0;
    end
  end

endmodule

// File: rtl/ni_flit_tx.sv
// NI packetizer: cmd -> HEAD, payload beats -> BODY.../TAIL; each flit one cycle
// after its handshake. Stalls cmd/data while the output slot is occupied.
module ni_flit_tx
  import ni_flit_tx_pkg::*;
#(
  parameter int ROUTER_X_ID = 0,
  parameter int ROUTER_Y_ID = 0,
  parameter int NOC_SZ_X    = 2,
  parameter int NOC_SZ_Y    = 2
) (
  input  logic         clk,
  input  logic         arst,
  ni_flit_tx_if.slave  bus,
  output logic         busy_o,
  output logic         cmd_err_o
);

  ni_state_t             state, state_nxt;
  logic [PKT_WIDTH-1:0]  cnt, cnt_nxt;
  logic                  err_nxt;
  logic                  slot_free;
  logic                  load;
  logic [FLIT_WIDTH-1:0] load_dat;
  logic                  dest_ok;
  s_flit_head_data_t     head;

  assign dest_ok = (int'(bus.cmd_x_dest_i) < NOC_SZ_X) &&
                   (int'(bus.cmd_y_dest_i) < NOC_SZ_Y);

  always_comb begin
    head           = '0;
    head.flit_type = HEAD_FLIT;
    head.x_dest    = bus.cmd_x_dest_i;
    head.y_dest    = bus.cmd_y_dest_i;
    head.x_src     = X_WIDTH'(ROUTER_X_ID);
    head.y_src     = Y_WIDTH'(ROUTER_Y_ID);
    head.pkt_len   = {1'b0, bus.cmd_len_i} + (PKT_WIDTH+1)'(1);
  end

  always_comb begin
    state_nxt        = state;
    cnt_nxt          = cnt;
    err_nxt          = 1'b0;
    load             = 1'b0;
    load_dat         = '0;
    bus.cmd_ready_o  = 1'b0;
    bus.data_ready_o = 1'b0;
    unique case (state)
      ST_IDLE: begin
        bus.cmd_ready_o = slot_free && !arst;
        if (bus.cmd_valid_i && bus.cmd_ready_o) begin
          cnt_nxt = bus.cmd_len_i;
          if (dest_ok) begin
            load      = 1'b1;
            load_dat  = head;
            state_nxt = ST_PAYLOAD;
          end else begin
            err_nxt   = 1'b1;
            state_nxt = ST_DRAIN;
          end
        end
      end
      ST_PAYLOAD: begin
        bus.data_ready_o = slot_free && !arst;
        if (bus.data_valid_i && bus.data_ready_o) begin
          load     = 1'b1;
          load_dat = mk_flit((cnt == '0) ? TAIL_FLIT : BODY_FLIT, bus.data_i);
          if (cnt == '0) state_nxt = ST_IDLE;
          else           cnt_nxt   = cnt - PKT_WIDTH'(1);
        end
      end
      ST_DRAIN: begin
        // Illegal destination: swallow the promised beats so the tile stays in sync.
        bus.data_ready_o = !arst;
        if (bus.data_valid_i && bus.data_ready_o) begin
          if (cnt == '0) state_nxt = ST_IDLE;
          else           cnt_nxt   = cnt - PKT_WIDTH'(1);
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (arst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      cmd_err_o <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      cmd_err_o <= err_nxt;
    end
  end

  flit_out_slot u_slot (
    .clk       (clk),
    .arst      (arst),
    .load      (load),
    .load_dat  (load_dat),
    .fout_req  (bus.fout_req_o),
    .fout_resp (bus.fout_resp_i),
    .slot_free (slot_free)
  );

  assign busy_o = (state != ST_IDLE) || bus.fout_req_o.fvalid;

endmodule

// File: tb/tb_ni_flit_tx.sv
// Directed bench for ni_flit_tx on a 2x2 mesh with source (0,0).
module tb_ni_flit_tx;
  import ni_flit_tx_pkg::*;

  logic clk = 1'b0;
  logic arst;
  logic busy, err;

  ni_flit_tx_if bus ();

  ni_flit_tx #(
    .ROUTER_X_ID (0),
    .ROUTER_Y_ID (0),
    .NOC_SZ_X    (2),
    .NOC_SZ_Y    (2)
  ) dut (
    .clk       (clk),
    .arst      (arst),
    .bus       (bus.slave),
    .busy_o    (busy),
    .cmd_err_o (err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string nm, input logic [33:0] act, input logic [33:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic cv, input logic [1:0] x, input logic [1:0] y,
                       input logic [7:0] len, input logic dv, input logic [31:0] d,
                       input logic rdy);
    arst                   = r;
    bus.cmd_valid_i        = cv;
    bus.cmd_x_dest_i       = x;
    bus.cmd_y_dest_i       = y;
    bus.cmd_len_i          = len;
    bus.data_valid_i       = dv;
    bus.data_i             = d;
    bus.fout_resp_i.ready  = rdy;
  endtask

  typedef struct {
    logic        rst, cv;
    logic [1:0]  x, y;
    logic [7:0]  len;
    logic        dv;
    logic [31:0] d;
    logic        rdy;
    logic        chk;
    logic        fv;
    logic [33:0] fd;
    logic        cr, dr, bz, er;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic rst, input logic cv, input logic [1:0] x, input logic [1:0] y,
                     input logic [7:0] len, input logic dv, input logic [31:0] d,
                     input logic rdy, input logic chk, input logic fv, input logic [33:0] fd,
                     input logic cr, input logic dr, input logic bz, input logic er);
    vec_t v;
    v.rst = rst; v.cv = cv; v.x = x; v.y = y; v.len = len; v.dv = dv; v.d = d; v.rdy = rdy;
    v.chk = chk; v.fv = fv; v.fd = fd; v.cr = cr; v.dr = dr; v.bz = bz; v.er = er;
    vq.push_back(v);
  endtask

  task automatic step(input logic r, input logic cv, input logic [1:0] x, input logic [1:0] y,
                      input logic [7:0] len, input logic dv, input logic [31:0] d,
                      input logic rdy);
    @(posedge clk);
    #1;
    drive(r, cv, x, y, len, dv, d, rdy);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [33:0] fl_log[$];
    int          cyc_log[$];
    logic [33:0] b2b_exp[6];
    int          sent;
    int          beat;

    drive(1'b1, 1'b0, 2'd0, 2'd0, 8'd0, 1'b0, 32'd0, 1'b1);

    // rst cv x y len dv data rdy | chk fv flit cr dr busy err
    add(1, 0, 0, 0, 0, 0, 32'h0,         1, 0, 0, 34'h0,           0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 32'h0,         1, 1, 0, 34'h0,           0, 0, 0, 0);
    add(0, 1, 1, 0, 0, 0, 32'h0,         1, 1, 0, 34'h0,           1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 1, 32'hA5A5A5A5,  1, 1, 1, 34'h0_4000_8000, 0, 1, 1, 0);
    add(0, 0, 0, 0, 0, 0, 32'h0,         1, 1, 1, 34'h2_A5A5_A5A5, 1, 0, 1, 0);
    add(0, 0, 0, 0, 0, 0, 32'h0,         1, 1, 0, 34'h0,           1, 0, 0, 0);
    for (int i = 0; i < 5; i++)
      add(0, 0, 0, 0, 0, 1, 32'hDEADBEEF, 1, 1, 0, 34'h0,          1, 0, 0, 0);
    // x=2 is off the 2x2 mesh
    add(0, 1, 2, 0, 1, 0, 32'h0,         1, 1, 0, 34'h0,           1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 1, 32'h1111,      1, 1, 0, 34'h0,           0, 1, 1, 1);
    add(0, 0, 0, 0, 0, 1, 32'h2222,      1, 1, 0, 34'h0,           0, 1, 1, 0);
    add(0, 0, 0, 0, 0, 1, 32'h3333,      1, 1, 0, 34'h0,           1, 0, 0, 0);
    // len=3 to (1,1) with a 3-cycle router stall on BODY2
    add(0, 1, 1, 1, 3, 0, 32'h0,         1, 1, 0, 34'h0,           1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 1, 32'h1,         1, 1, 1, 34'h0_5002_0000, 0, 1, 1, 0);
    add(0, 0, 0, 0, 0, 1, 32'h2,         1, 1, 1, 34'h1_0000_0001, 0, 1, 1, 0);
    for (int i = 0; i < 3; i++)
      add(0, 0, 0, 0, 0, 1, 32'h3,       0, 1, 1, 34'h1_0000_0002, 0, 0, 1, 0);
    add(0, 0, 0, 0, 0, 1, 32'h3,         1, 1, 1, 34'h1_0000_0002, 0, 1, 1, 0);
    add(0, 0, 0, 0, 0, 1, 32'h4,         1, 1, 1, 34'h1_0000_0003, 0, 1, 1, 0);
    add(0, 0, 0, 0, 0, 0, 32'h0,         1, 1, 1, 34'h2_0000_0004, 1, 0, 1, 0);
    add(0, 0, 0, 0, 0, 0, 32'h0,         1, 1, 0, 34'h0,           1, 0, 0, 0);

    foreach (vq[i]) begin
      step(vq[i].rst, vq[i].cv, vq[i].x, vq[i].y, vq[i].len, vq[i].dv, vq[i].d, vq[i].rdy);
      if (vq[i].chk) begin
        check($sformatf("row%0d fvalid", i), 34'(bus.fout_req_o.fvalid), 34'(vq[i].fv));
        if (vq[i].fv)
          check($sformatf("row%0d flit", i), bus.fout_req_o.flit_data, vq[i].fd);
        check($sformatf("row%0d cmd_ready", i), 34'(bus.cmd_ready_o), 34'(vq[i].cr));
        check($sformatf("row%0d data_ready", i), 34'(bus.data_ready_o), 34'(vq[i].dr));
        check($sformatf("row%0d busy", i), 34'(busy), 34'(vq[i].bz));
        check($sformatf("row%0d cmd_err", i), 34'(err), 34'(vq[i].er));
      end
    end

    // Two len=1 packets to (1,0) back to back, beats offered continuously.
    b2b_exp[0] = 34'h0_4001_0000; b2b_exp[1] = 34'h1_0000_0011; b2b_exp[2] = 34'h2_0000_0022;
    b2b_exp[3] = 34'h0_4001_0000; b2b_exp[4] = 34'h1_0000_0033; b2b_exp[5] = 34'h2_0000_0044;
    sent = 0;
    beat = 0;
    for (int c = 0; c < 40 && fl_log.size() < 6; c++) begin
      step(1'b0, sent < 2, 2'd1, 2'd0, 8'd1, 1'b1, 32'(beat + 1) * 32'h11, 1'b1);
      if (bus.fout_req_o.fvalid) begin
        fl_log.push_back(bus.fout_req_o.flit_data);
        cyc_log.push_back(c);
      end
      if (bus.cmd_valid_i && bus.cmd_ready_o) sent++;
      if (bus.data_valid_i && bus.data_ready_o) beat++;
    end
    check("b2b flit count", 34'(fl_log.size()), 34'd6);
    if (fl_log.size() == 6) begin
      for (int i = 0; i < 6; i++)
        check($sformatf("b2b flit%0d", i), fl_log[i], b2b_exp[i]);
      check("b2b head2 gap", 34'(cyc_log[3] - cyc_log[2]), 34'd1);
      check("b2b pkt1 contiguous", 34'(cyc_log[2] - cyc_log[0]), 34'd2);
    end

    // Reset in the middle of a len=3 packet, then a fresh len=0 packet to (0,1).
    step(1'b0, 1'b0, 2'd0, 2'd0, 8'd0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b1, 2'd1, 2'd1, 8'd3, 1'b0, 32'h0, 1'b1);
    check("rst cmd accepted", 34'(bus.cmd_ready_o), 34'd1);
    step(1'b0, 1'b0, 2'd0, 2'd0, 8'd0, 1'b1, 32'hAAAA0001, 1'b1);
    check("rst head", bus.fout_req_o.flit_data, 34'h0_5002_0000);
    step(1'b1, 1'b0, 2'd0, 2'd0, 8'd0, 1'b1, 32'hAAAA0002, 1'b1);
    check("rst body", bus.fout_req_o.flit_data, 34'h1_AAAA_0001);
    check("rst cmd_ready in reset", 34'(bus.cmd_ready_o), 34'd0);
    check("rst data_ready in reset", 34'(bus.data_ready_o), 34'd0);
    step(1'b0, 1'b0, 2'd0, 2'd0, 8'd0, 1'b0, 32'h0, 1'b1);
    check("rst fvalid after", 34'(bus.fout_req_o.fvalid), 34'd0);
    check("rst busy after", 34'(busy), 34'd0);
    check("rst idle cmd_ready", 34'(bus.cmd_ready_o), 34'd1);
    check("rst idle data_ready", 34'(bus.data_ready_o), 34'd0);
    step(1'b0, 1'b1, 2'd0, 2'd1, 8'd0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b0, 2'd0, 2'd0, 8'd0, 1'b1, 32'h0000BEEF, 1'b1);
    check("rst new head vld", 34'(bus.fout_req_o.fvalid), 34'd1);
    check("rst new head", bus.fout_req_o.flit_data, 34'h0_1000_8000);
    check("rst new data_ready", 34'(bus.data_ready_o), 34'd1);
    step(1'b0, 1'b0, 2'd0, 2'd0, 8'd0, 1'b0, 32'h0, 1'b1);
    check("rst new tail", bus.fout_req_o.flit_data, 34'h2_0000_BEEF);
    check("rst new tail vld", 34'(bus.fout_req_o.fvalid), 34'd1);
    step(1'b0, 1'b0, 2'd0, 2'd0, 8'd0, 1'b0, 32'h0, 1'b1);
    check("rst final busy", 34'(busy), 34'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
